// File: rtl/core_pkg.sv
// core_pkg: opcodes, bubble word, instruction field layout and fetch FSM states shared by the pipeline stages.
package core_pkg;
  localparam logic [4:0] OP_JR = 5'b11000;
  localparam logic [4:0] OP_LOAD = 5'b11010;
  localparam logic [4:0] OP_BUBBLE = 5'h1f;
  localparam logic [15:0] BUBBLE_INSTR = 16'hFFFF;
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 11;
  localparam int RD_MSB = 10;
  localparam int RD_LSB = 8;
  localparam int R1_MSB = 7;
  localparam int R1_LSB = 5;
  localparam int R2_MSB = 4;
  localparam int R2_LSB = 2;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HOLD = 2'd2, FLUSH = 2'd3} fetch_state_t;
endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: combinational slicer of the opcode and register fields of a 16-bit instruction.
module instr_field_decode
  import core_pkg::*;
(
  input  logic [OP_MSB:R2_LSB] fields,
  output logic [4:0]           opcode,
  output logic [2:0]           rd_addr,
  output logic [2:0]           r1_addr,
  output logic [2:0]           r2_addr
);
  assign opcode  = fields[OP_MSB:OP_LSB];
  assign rd_addr = fields[RD_MSB:RD_LSB];
  assign r1_addr = fields[R1_MSB:R1_LSB];
  assign r2_addr = fields[R2_MSB:R2_LSB];
endmodule

// File: rtl/ifid_fetch_stage.sv
// ifid_fetch_stage: PC, fetch FSM and IF/ID register with stall hold and jr flush.
// Define IFID_PERF_CNT_EN to add the STALL_CYCLES / FLUSH_COUNT counters.
module ifid_fetch_stage #(
  parameter int               PC_W         = 8,
  parameter logic [PC_W-1:0]  RESET_PC     = '0,
  parameter logic [15:0]      BUBBLE_INSTR = core_pkg::BUBBLE_INSTR
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STALL,
  input  logic            REDIRECT_VALID,
  input  logic [PC_W-1:0] REDIRECT_PC,
  output logic [PC_W-1:0] IMEM_ADDR,
  input  logic [15:0]     IMEM_DATA,
  output logic [15:0]     IFID_INSTR,
  output logic [PC_W-1:0] IFID_PC,
  output logic            IFID_VALID,
  output logic [4:0]      IFID_OPCODE,
  output logic [2:0]      IFID_RD_ADDR,
  output logic [2:0]      IFID_R1_ADDR,
  output logic [2:0]      IFID_R2_ADDR,
  output logic [1:0]      FETCH_STATE
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [15:0]     STALL_CYCLES,
  output logic [15:0]     FLUSH_COUNT
`endif
);
  import core_pkg::*;
  fetch_state_t state, state_nx;
  logic [PC_W-1:0] pc;
  logic redirect, hold;
  // BOOT always fetches; every other state reacts to redirect before stall
  assign redirect = state != BOOT && REDIRECT_VALID;
  assign hold = state != BOOT && !REDIRECT_VALID && STALL;
  always_comb begin
    state_nx = redirect ? FLUSH : hold ? HOLD : RUN;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      IFID_INSTR <= BUBBLE_INSTR;
      IFID_PC    <= '0;
      IFID_VALID <= 1'b0;
    end else begin
      state <= state_nx;
      if (redirect) begin
        pc         <= REDIRECT_PC;
        IFID_INSTR <= BUBBLE_INSTR;
        IFID_PC    <= '0;
        IFID_VALID <= 1'b0;
      end else if (!hold) begin
        pc         <= pc + PC_W'(1);
        IFID_INSTR <= IMEM_DATA;
        IFID_PC    <= pc;
        IFID_VALID <= 1'b1;
      end
    end
  end
  assign IMEM_ADDR = pc;
  assign FETCH_STATE = state;
  instr_field_decode u_dec (
    .fields  (IFID_INSTR[OP_MSB:R2_LSB]),
    .opcode  (IFID_OPCODE),
    .rd_addr (IFID_RD_ADDR),
    .r1_addr (IFID_R1_ADDR),
    .r2_addr (IFID_R2_ADDR)
  );
`ifdef IFID_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      STALL_CYCLES <= '0;
      FLUSH_COUNT  <= '0;
    end else begin
      if (hold && STALL_CYCLES != 16'hFFFF) STALL_CYCLES <= STALL_CYCLES + 16'd1;
      if (redirect && FLUSH_COUNT != 16'hFFFF) FLUSH_COUNT <= FLUSH_COUNT + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ifid_fetch_stage.sv
// tb_ifid_fetch_stage: directed vector table plus randomized run against a transaction-level fetch model.
module tb_ifid_fetch_stage;
  logic        CLK = 0, RST = 1, STALL = 0, REDIRECT_VALID = 0;
  logic [7:0]  REDIRECT_PC = 0, IMEM_ADDR, IFID_PC;
  logic [15:0] IMEM_DATA, IFID_INSTR;
  logic        IFID_VALID;
  logic [4:0]  IFID_OPCODE;
  logic [2:0]  IFID_RD_ADDR, IFID_R1_ADDR, IFID_R2_ADDR;
  logic [1:0]  FETCH_STATE;
`ifdef IFID_PERF_CNT_EN
  logic [15:0] STALL_CYCLES, FLUSH_COUNT;
`endif
  logic [15:0] mem [256];
  int errors = 0, checks = 0;
  int m_pc = 0, m_ifpc = 0, m_valid = 0, m_state = 0, m_stalls = 0, m_flushes = 0;
  logic [15:0] m_instr = 16'hFFFF;
  typedef struct {
    logic rst, stall, redir;
    logic [7:0] rpc, pc, ifpc;
    logic valid;
    logic [15:0] instr;
    logic [1:0] st;
  } vec_t;
  vec_t vt [23];

  ifid_fetch_stage dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .REDIRECT_VALID(REDIRECT_VALID), .REDIRECT_PC(REDIRECT_PC),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_DATA(IMEM_DATA), .IFID_INSTR(IFID_INSTR), .IFID_PC(IFID_PC),
    .IFID_VALID(IFID_VALID), .IFID_OPCODE(IFID_OPCODE), .IFID_RD_ADDR(IFID_RD_ADDR),
    .IFID_R1_ADDR(IFID_R1_ADDR), .IFID_R2_ADDR(IFID_R2_ADDR), .FETCH_STATE(FETCH_STATE)
`ifdef IFID_PERF_CNT_EN
    , .STALL_CYCLES(STALL_CYCLES), .FLUSH_COUNT(FLUSH_COUNT)
`endif
  );

  assign IMEM_DATA = mem[IMEM_ADDR];
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int pc, input int ifpc, input int valid,
                         input logic [15:0] instr, input int st);
    chk({tag, " pc"}, IMEM_ADDR, pc);
    chk({tag, " ifid_pc"}, IFID_PC, ifpc);
    chk({tag, " valid"}, IFID_VALID, valid);
    chk({tag, " instr"}, IFID_INSTR, instr);
    chk({tag, " opcode"}, IFID_OPCODE, instr >> 11);
    chk({tag, " rd"}, IFID_RD_ADDR, (instr >> 8) & 7);
    chk({tag, " r1"}, IFID_R1_ADDR, (instr >> 5) & 7);
    chk({tag, " r2"}, IFID_R2_ADDR, (instr >> 2) & 7);
    chk({tag, " state"}, FETCH_STATE, st);
`ifdef IFID_PERF_CNT_EN
    chk({tag, " stall_cycles"}, STALL_CYCLES, m_stalls);
    chk({tag, " flush_count"}, FLUSH_COUNT, m_flushes);
`endif
  endtask

  // One clock edge with the given inputs; the model advances by one pipeline transaction.
  task automatic step(input logic r, input logic s, input logic v, input logic [7:0] t);
    logic [15:0] d;
    RST = r; STALL = s; REDIRECT_VALID = v; REDIRECT_PC = t;
    d = mem[m_pc];
    @(posedge CLK);
    #1;
    if (r) begin
      m_pc = 0; m_instr = 16'hFFFF; m_ifpc = 0; m_valid = 0; m_state = 0; m_stalls = 0; m_flushes = 0;
    end else if (m_state != 0 && v) begin
      m_pc = t; m_instr = 16'hFFFF; m_ifpc = 0; m_valid = 0; m_state = 3;
      if (m_flushes < 65535) m_flushes++;
    end else if (m_state != 0 && s) begin
      m_state = 2;
      if (m_stalls < 65535) m_stalls++;
    end else begin
      m_instr = d; m_ifpc = m_pc; m_valid = 1; m_pc = (m_pc + 1) % 256; m_state = 1;
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h1000 + 16'(a);
    vt[0]  = '{1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 16'hFFFF, 2'd0};
    vt[1]  = '{1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 16'hFFFF, 2'd0};
    vt[2]  = '{0, 0, 0, 8'h00, 8'h01, 8'h00, 1, 16'h1000, 2'd1};
    vt[3]  = '{0, 0, 0, 8'h00, 8'h02, 8'h01, 1, 16'h1001, 2'd1};
    vt[4]  = '{0, 0, 0, 8'h00, 8'h03, 8'h02, 1, 16'h1002, 2'd1};
    vt[5]  = '{0, 0, 0, 8'h00, 8'h04, 8'h03, 1, 16'h1003, 2'd1};
    vt[6]  = '{0, 1, 0, 8'h00, 8'h04, 8'h03, 1, 16'h1003, 2'd2};
    vt[7]  = '{0, 1, 0, 8'h00, 8'h04, 8'h03, 1, 16'h1003, 2'd2};
    vt[8]  = '{0, 0, 0, 8'h00, 8'h05, 8'h04, 1, 16'h1004, 2'd1};
    vt[9]  = '{0, 0, 0, 8'h00, 8'h06, 8'h05, 1, 16'h1005, 2'd1};
    vt[10] = '{0, 0, 1, 8'h40, 8'h40, 8'h00, 0, 16'hFFFF, 2'd3};
    vt[11] = '{0, 0, 0, 8'h00, 8'h41, 8'h40, 1, 16'h1040, 2'd1};
    vt[12] = '{0, 1, 1, 8'h80, 8'h80, 8'h00, 0, 16'hFFFF, 2'd3};
    vt[13] = '{0, 0, 0, 8'h00, 8'h81, 8'h80, 1, 16'h1080, 2'd1};
    vt[14] = '{0, 0, 1, 8'hFF, 8'hFF, 8'h00, 0, 16'hFFFF, 2'd3};
    vt[15] = '{0, 0, 0, 8'h00, 8'h00, 8'hFF, 1, 16'h10FF, 2'd1};
    vt[16] = '{0, 0, 0, 8'h00, 8'h01, 8'h00, 1, 16'h1000, 2'd1};
    vt[17] = '{0, 1, 0, 8'h00, 8'h01, 8'h00, 1, 16'h1000, 2'd2};
    vt[18] = '{1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 16'hFFFF, 2'd0};
    vt[19] = '{0, 1, 1, 8'h55, 8'h01, 8'h00, 1, 16'h1000, 2'd1};
    vt[20] = '{0, 0, 1, 8'h10, 8'h10, 8'h00, 0, 16'hFFFF, 2'd3};
    vt[21] = '{0, 0, 1, 8'h20, 8'h20, 8'h00, 0, 16'hFFFF, 2'd3};
    vt[22] = '{0, 0, 0, 8'h00, 8'h21, 8'h20, 1, 16'h1020, 2'd1};
    for (int i = 0; i < 23; i++) begin
      step(vt[i].rst, vt[i].stall, vt[i].redir, vt[i].rpc);
      chk_all($sformatf("vec%0d", i), vt[i].pc, vt[i].ifpc, vt[i].valid, vt[i].instr, vt[i].st);
    end
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           8'($urandom));
      chk_all($sformatf("rnd%0d", i), m_pc, m_ifpc, m_valid, m_instr, m_state);
    end
`ifdef IFID_PERF_CNT_EN
    for (int i = 0; i < 65540; i++) step(0, 1, 0, 8'h00);
    chk("stall_cycles saturated", STALL_CYCLES, 16'hFFFF);
    chk_all("sat", m_pc, m_ifpc, m_valid, m_instr, m_state);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
